// File: rtl/lut_z_reader_pkg.sv
// ---------------------------------------------------------------------------
// lut_z_reader_pkg
// Shared definitions for the Z-constant ROM read sequencer and its skid FIFO:
//   - state_t      : sequencer states (IDLE / RUN / FIN)
//   - FIFO_DEPTH   : entries in the skid FIFO between ROM and consumer
//   - FIFO_CW      : width of the FIFO occupancy count
//   - P_DEFAULT    : default ROM data width (IEEE-754 single)
//   - D_DEFAULT    : default ROM address width
// ---------------------------------------------------------------------------
package lut_z_reader_pkg;

  localparam int P_DEFAULT  = 32;
  localparam int D_DEFAULT  = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/lut_z_skid_fifo.sv
// ---------------------------------------------------------------------------
// lut_z_skid_fifo
// Two-entry synchronous FIFO holding {last, idx, data} words between the
// registered ROM and the Z-path consumer. Slot 0 is always the head, so the
// head word is a plain register output and stays stable while not popped.
// Ports:
//   CLK, RST_N  : clock (rising edge), asynchronous active-low reset
//   flush       : discard all entries (takes priority over push/pop)
//   push        : write push_data this cycle
//   push_data   : word to write
//   pop         : remove the head word this cycle
//   head        : current head word
//   count       : number of valid entries (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module lut_z_skid_fifo
  import lut_z_reader_pkg::*;
#(
  parameter int W = 38
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               flush,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [W-1:0]       head,
  output logic [FIFO_CW-1:0] count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         pop_ok;
  logic         push_ok;

  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle, so the occupancy can never exceed the depth.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count < FIFO_CW'(FIFO_DEPTH)) || pop_ok);
  assign head    = slot0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == '0) slot0 <= push_data;
          else             slot1 <= push_data;
          count <= count + FIFO_CW'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - FIFO_CW'(1);
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; with one entry the new
          // word becomes the head directly, with two it queues behind slot1.
          if (count == FIFO_CW'(1)) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lut_z_reader.sv
// ---------------------------------------------------------------------------
// lut_z_reader
// Read-side sequencer for the registered Z-constant ROM. After START it reads
// ROM addresses 0..ITERS-1, buffers each constant in a 2-entry skid FIFO and
// presents them in order on a valid/ready stream to the CORDIC Z-path.
// Optional feature macro: LUT_Z_READER_ABORT_EN (adds input ABORT).
// Ports:
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   START      : one-cycle request to begin a sequence (ignored while busy)
//   ITERS      : iteration count 0..2^D, sampled with START
//   ABORT      : (macro only) stop the running sequence, flush, pulse DONE
//   BUSY       : high while a sequence is running
//   DONE       : one-cycle pulse after the last constant is accepted
//   EN_ROM1    : ROM read enable
//   ADRS       : ROM address (holds last issued address when idle)
//   ROM_DATA   : ROM registered output, valid the cycle after EN_ROM1
//   Z_VALID    : stream valid
//   Z_READY    : stream ready
//   Z_DATA     : constant
//   Z_IDX      : ROM address the constant came from
//   Z_LAST     : marks the final constant of the sequence
// ---------------------------------------------------------------------------
module lut_z_reader
  import lut_z_reader_pkg::*;
#(
  parameter int P = P_DEFAULT,
  parameter int D = D_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [D:0]   ITERS,
`ifdef LUT_Z_READER_ABORT_EN
  input  logic         ABORT,
`endif
  output logic         BUSY,
  output logic         DONE,
  output logic         EN_ROM1,
  output logic [D-1:0] ADRS,
  input  logic [P-1:0] ROM_DATA,
  output logic         Z_VALID,
  input  logic         Z_READY,
  output logic [P-1:0] Z_DATA,
  output logic [D-1:0] Z_IDX,
  output logic         Z_LAST
);

  localparam int FW = P + D + 1;

  state_t               state;
  state_t               state_next;
  logic [D:0]           n_q;
  logic [D:0]           issue_cnt;
  logic [D-1:0]         adrs_q;
  logic                 inflight;
  logic                 abort_req;
  logic                 issue;
  logic                 pop;
  logic                 push;
  logic                 push_last;
  logic [FW-1:0]        head;
  logic [FW-1:0]        push_data;
  logic [FIFO_CW-1:0]   count;
  logic [FIFO_CW:0]     occupancy;

`ifdef LUT_Z_READER_ABORT_EN
  assign abort_req = ABORT && (state == ST_RUN);
`else
  assign abort_req = 1'b0;
`endif

  // Occupancy counts FIFO entries plus the read still in the ROM pipeline,
  // and credits a pop happening this cycle so a steady ready stream sustains
  // one read per cycle without ever overfilling the FIFO.
  assign pop       = Z_VALID && Z_READY;
  assign occupancy = {1'b0, count} + (FIFO_CW + 1)'(inflight) - (FIFO_CW + 1)'(pop);
  assign issue     = (state == ST_RUN) && !abort_req && (issue_cnt < n_q) &&
                     (occupancy < (FIFO_CW + 1)'(FIFO_DEPTH));

  assign EN_ROM1 = issue;
  assign ADRS    = issue ? issue_cnt[D-1:0] : adrs_q;

  // The in-flight read's address is the last address issued.
  assign push_last = ({1'b0, adrs_q} == (n_q - (D + 1)'(1)));
  assign push      = inflight && !abort_req;
  assign push_data = {push_last, adrs_q, ROM_DATA};

  lut_z_skid_fifo #(
    .W (FW)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (abort_req),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign Z_VALID = (count != '0);
  assign Z_DATA  = head[P-1:0];
  assign Z_IDX   = head[P+D-1:P];
  assign Z_LAST  = head[P+D];

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_FIN);

  // Next-state logic: a zero-length request skips straight to FIN so the
  // requester still sees a DONE pulse without any ROM traffic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (START) state_next = (ITERS != '0) ? ST_RUN : ST_FIN;
      end
      ST_RUN: begin
        if (abort_req || (pop && Z_LAST)) state_next = ST_FIN;
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, sequence length, issue counter and ROM pipeline tracking.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      n_q       <= '0;
      issue_cnt <= '0;
      adrs_q    <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if ((state == ST_IDLE) && START) begin
        n_q       <= ITERS;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + (D + 1)'(1);
        adrs_q    <= issue_cnt[D-1:0];
      end
    end
  end

endmodule

// File: tb/tb_lut_z_reader.sv
// ---------------------------------------------------------------------------
// tb_lut_z_reader
// Self-checking bench for lut_z_reader: a ROM model with 1-cycle latency, a
// scoreboard queue of expected beats filled when START is issued, and a
// negedge monitor that pops and compares every accepted beat.
// ---------------------------------------------------------------------------
module tb_lut_z_reader;

  localparam int P = 32;
  localparam int D = 5;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [D:0]   ITERS = '0;
  logic         Z_READY = 1'b0;
  logic [P-1:0] ROM_DATA = '0;
  logic         BUSY, DONE, EN_ROM1, Z_VALID, Z_LAST;
  logic [D-1:0] ADRS, Z_IDX;
  logic [P-1:0] Z_DATA;

  typedef struct {
    logic [D-1:0] idx;
    logic [P-1:0] data;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [P-1:0] rom [0:(1<<D)-1];

  int n_cmp = 0;
  int n_fail = 0;

  // Per-sequence observations collected by the monitor.
  int           cyc = 0;
  int           exp_adrs = 0;
  int           seq_issues = 0;
  int           seq_accepts = 0;
  int           max_out = 0;
  int           busy_cnt = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           first_cyc = 0;
  int           last_cyc = 0;
  bit           first_seen = 0;
  logic [P-1:0] first_data = '0;
  logic [P-1:0] last_data = '0;
  logic [D-1:0] first_idx = '0;
  logic [D-1:0] last_idx = '0;
  bit           prev_stall = 0;
  logic [P+D:0] prev_beat = '0;

  int ready_mode = 0;
  int stall_left = 0;
  bit stall_started = 0;

  always #5 CLK = ~CLK;

  lut_z_reader #(
    .P (P),
    .D (D)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .ITERS    (ITERS),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .EN_ROM1  (EN_ROM1),
    .ADRS     (ADRS),
    .ROM_DATA (ROM_DATA),
    .Z_VALID  (Z_VALID),
    .Z_READY  (Z_READY),
    .Z_DATA   (Z_DATA),
    .Z_IDX    (Z_IDX),
    .Z_LAST   (Z_LAST)
  );

  // Registered ROM: one cycle of latency, zero output when not enabled.
  always @(posedge CLK) begin
    ROM_DATA <= EN_ROM1 ? rom[ADRS] : '0;
  end

  // Consumer ready pattern, changed well after the clock edge.
  always @(posedge CLK) begin
    #2;
    case (ready_mode)
      0: Z_READY = 1'b1;
      1: Z_READY = 1'($urandom_range(0, 1));
      2: Z_READY = ~Z_READY;
      default: begin
        if ((stall_left > 0) && (Z_VALID || stall_started)) begin
          Z_READY = 1'b0;
          stall_started = 1;
          stall_left--;
        end else begin
          Z_READY = 1'b1;
        end
      end
    endcase
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: looks at the handshake that the next rising edge will perform.
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_stall = 0;
    end else begin
      cyc++;
      if (prev_stall)
        check_output("stall_hold", {Z_VALID, Z_LAST, Z_IDX, Z_DATA}, {1'b1, prev_beat});
      prev_stall = Z_VALID && !Z_READY;
      prev_beat  = {Z_LAST, Z_IDX, Z_DATA};
      if (EN_ROM1) begin
        check_output("rom_adrs", 64'(ADRS), 64'(exp_adrs));
        exp_adrs++;
        seq_issues++;
      end
      if (Z_VALID && Z_READY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_beat: got idx %0d, expected no beat", Z_IDX);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check_output("beat", {Z_LAST, Z_IDX, Z_DATA}, {b.last, b.idx, b.data});
        end
        if (!first_seen) begin
          first_seen = 1;
          first_cyc  = cyc;
          first_data = Z_DATA;
          first_idx  = Z_IDX;
        end
        last_cyc  = cyc;
        last_data = Z_DATA;
        last_idx  = Z_IDX;
        seq_accepts++;
      end
      if (seq_issues - seq_accepts > max_out) max_out = seq_issues - seq_accepts;
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (BUSY) busy_cnt++;
    end
  end

  // Runs one sequence of n constants under the given ready pattern.
  // poke pulses a stray START mid-sequence; reset_beat>0 resets the DUT once
  // that many beats have been accepted.
  task automatic apply_stimulus(input int n, input int mode, input bit poke, input int reset_beat);
    int  done_before;
    int  lat;
    bit  got_valid;
    bit  finished;
    ready_mode    = mode;
    stall_left    = (mode == 3) ? 5 : 0;
    stall_started = 0;
    exp_adrs      = 0;
    seq_issues    = 0;
    seq_accepts   = 0;
    max_out       = 0;
    busy_cnt      = 0;
    first_seen    = 0;
    done_before   = done_cnt;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.idx  = D'(i);
      b.data = rom[i];
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    @(posedge CLK); #1;
    START = 1'b1;
    ITERS = (D + 1)'(n);
    lat = 0;
    got_valid = 0;
    finished = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      if (!got_valid && Z_VALID) begin
        got_valid = 1;
        lat = c + 1;
      end
      if (poke && (c == 10)) begin
        START = 1'b1;
        ITERS = (D + 1)'($urandom_range(1, 32));
      end
      if ((reset_beat > 0) && (seq_accepts >= reset_beat)) begin
        RST_N = 1'b0;
        #1;
        check_output("reset_outputs",
                     64'({BUSY, DONE, EN_ROM1, ADRS, Z_VALID, Z_DATA, Z_IDX, Z_LAST}), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check_output("no_done_after_reset", 64'(done_cnt), 64'(done_before));
        return;
      end
      if (done_cnt != done_before) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL done_timeout: got no DONE, expected DONE for ITERS=%0d", n);
      return;
    end
    repeat (40) @(posedge CLK);
    #1;
    check_output("done_pulses", 64'(done_cnt - done_before), 64'd1);
    check_output("rom_reads", 64'(seq_issues), 64'(n));
    check_output("outstanding_le_2", 64'(max_out <= 2), 64'd1);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    if (n > 0) begin
      check_output("start_to_valid", 64'(lat), 64'd3);
      check_output("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    end else begin
      check_output("busy_cycles", 64'(busy_cnt), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << D); i++) rom[i] = $urandom;
    rom[0]  = 32'hBF8C9F54;
    rom[1]  = 32'hBF02C578;
    rom[31] = 32'hB1000000;

    $display("[TB] reset");
    repeat (3) @(posedge CLK);
    #1;
    check_output("reset_state",
                 64'({BUSY, DONE, EN_ROM1, ADRS, Z_VALID, Z_DATA, Z_IDX, Z_LAST}), 64'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] two constants");
    apply_stimulus(2, 0, 0, 0);
    check_output("first_data", 64'(first_data), 64'h0BF8C9F54);
    check_output("last_data", 64'(last_data), 64'h0BF02C578);

    $display("[TB] full 32-entry walk");
    apply_stimulus(32, 0, 0, 0);
    check_output("last_idx", 64'(last_idx), 64'd31);
    check_output("last_data_32", 64'(last_data), 64'h0B1000000);
    check_output("back_to_back", 64'(last_cyc - first_cyc), 64'd31);

    $display("[TB] stall after first valid");
    apply_stimulus(4, 3, 0, 0);
    check_output("stall_first_data", 64'(first_data), 64'h0BF8C9F54);

    $display("[TB] zero iterations");
    apply_stimulus(0, 0, 0, 0);

    $display("[TB] toggling ready with stray START");
    apply_stimulus(8, 2, 1, 0);

    $display("[TB] reset mid-sequence");
    apply_stimulus(8, 0, 0, 3);
    apply_stimulus(8, 0, 0, 0);
    check_output("restart_idx", 64'(first_idx), 64'd0);

    $display("[TB] random sequences");
    for (int k = 0; k < 4; k++) apply_stimulus(int'($urandom_range(1, 32)), 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
